// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: programs the UART receiver config registers, buffers received bytes
// in a FIFO, tracks receive errors and resyncs the receiver after a run of errors.
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int ERR_THRESH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] cfg_div,
   input  logic [7:0]  cfg_ctrl,
   output logic        busy,
   output logic [3:0]  c_addr,
   output logic [7:0]  c_data,
   output logic        c_valid,
   input  logic        c_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic [1:0]  rx_error,
   input  logic        rx_error_valid,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  err_count,
   output logic [1:0]  last_error,
   output logic        overflow,
   output logic        resync
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_LO   = 3'd1;
   localparam logic [2:0] S_WR_HI   = 3'd2;
   localparam logic [2:0] S_WR_CTRL = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;

   logic [2:0]    r_state;
   logic [15:0]   r_div;
   logic [7:0]    r_ctrl;
   logic          r_c_valid;
   logic [3:0]    r_c_addr;
   logic [7:0]    r_c_data;
   logic          r_resync;
   logic [7:0]    r_err_count;
   logic [1:0]    r_last_error;
   logic [3:0]    r_consec;
   logic          r_overflow;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;

   logic       w_busy;
   logic       w_run;
   logic       w_start_acc;
   logic       w_c_fire;
   logic       w_err;
   logic [3:0] w_consec_nxt;
   logic       w_consec_hit;
   logic       w_empty;
   logic       w_full;
   logic       w_pop;
   logic       w_push_req;
   logic       w_push;
   logic       w_drop;

   assign w_busy       = (r_state == S_WR_LO) || (r_state == S_WR_HI) || (r_state == S_WR_CTRL);
   assign w_run        = r_state == S_RUN;
   assign w_start_acc  = start & ~w_busy;
   assign w_c_fire     = r_c_valid & c_ready;
   assign w_err        = w_run & rx_error_valid;
   assign w_consec_nxt = r_consec + 4'd1;
   assign w_consec_hit = w_err && (w_consec_nxt == 4'(ERR_THRESH));
   assign w_empty      = r_cnt == '0;
   assign w_full       = r_cnt == (AW+1)'(FIFO_DEPTH);
   assign w_pop        = ~w_empty & m_ready;
   assign w_push_req   = w_run & rx_valid;
   assign w_push       = w_push_req & (~w_full | w_pop);
   assign w_drop       = w_push_req & w_full & ~w_pop;

   // A user start takes priority over an error-triggered resync in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_ctrl    <= '0;
         r_c_valid <= 1'b0;
         r_c_addr  <= '0;
         r_c_data  <= '0;
         r_resync  <= 1'b0;
      end else begin
         r_resync <= 1'b0;
         if (w_start_acc) begin
            r_state   <= S_WR_LO;
            r_div     <= cfg_div;
            r_ctrl    <= cfg_ctrl;
            r_c_valid <= 1'b1;
            r_c_addr  <= 4'd0;
            r_c_data  <= cfg_div[7:0];
         end else if (w_consec_hit) begin
            r_state   <= S_WR_LO;
            r_resync  <= 1'b1;
            r_c_valid <= 1'b1;
            r_c_addr  <= 4'd0;
            r_c_data  <= r_div[7:0];
         end else if (w_c_fire) begin
            r_state   <= (r_state == S_WR_LO) ? S_WR_HI : (r_state == S_WR_HI) ? S_WR_CTRL : S_RUN;
            r_c_valid <= r_state != S_WR_CTRL;
            r_c_addr  <= (r_state == S_WR_CTRL) ? r_c_addr : r_c_addr + 4'd1;
            r_c_data  <= (r_state == S_WR_LO) ? r_div[15:8] : (r_state == S_WR_HI) ? r_ctrl : r_c_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_count  <= '0;
         r_last_error <= '0;
         r_consec     <= '0;
      end else if (w_start_acc) begin
         r_err_count  <= '0;
         r_last_error <= '0;
         r_consec     <= '0;
      end else if (w_err) begin
         r_err_count  <= (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;
         r_last_error <= rx_error;
         r_consec     <= w_consec_hit ? 4'd0 : w_consec_nxt;
      end else if (w_push_req) begin
         r_consec <= '0;
      end
   end

   // FIFO contents only clear on rst; start and resync leave them intact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= rx_data;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt      <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
         r_overflow <= w_start_acc ? 1'b0 : (w_drop ? 1'b1 : r_overflow);
      end
   end

   assign busy       = w_busy;
   assign c_valid    = r_c_valid;
   assign c_addr     = r_c_addr;
   assign c_data     = r_c_data;
   assign resync     = r_resync;
   assign err_count  = r_err_count;
   assign last_error = r_last_error;
   assign overflow   = r_overflow;
   assign m_valid    = ~w_empty;
   assign m_data     = r_mem[r_rp];
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed stimulus with a queue-based reference model checked every
// cycle, plus literal expectations for config writes, FIFO order, overflow and errors.
module tb_uart_rx_ctrl;
   localparam int DEPTH  = 4;
   localparam int THRESH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start = 1'b0, c_ready = 1'b1, rx_valid = 1'b0, rx_error_valid = 1'b0, m_ready = 1'b0;
   logic [15:0] cfg_div = '0;
   logic [7:0]  cfg_ctrl = '0, rx_data = '0;
   logic [1:0]  rx_error = '0;
   logic        busy, c_valid, m_valid, overflow, resync;
   logic [3:0]  c_addr;
   logic [7:0]  c_data, m_data, err_count;
   logic [1:0]  last_error;
   logic        busy15, c_valid15, m_valid15, overflow15, resync15;
   logic [3:0]  c_addr15;
   logic [7:0]  c_data15, m_data15, err_count15;
   logic [1:0]  last_error15;

   int checks = 0, errors = 0;
   bit chk_on = 0;
   logic [11:0] wlog[$];
   logic [7:0]  plog[$];
   int nbusy = 0, nres = 0, nres15 = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .ERR_THRESH(THRESH)) u_dut (
      .clk(clk), .rst(rst), .start(start), .cfg_div(cfg_div), .cfg_ctrl(cfg_ctrl),
      .busy(busy), .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .rx_error_valid(rx_error_valid),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .err_count(err_count),
      .last_error(last_error), .overflow(overflow), .resync(resync));

   uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .ERR_THRESH(15)) u_dut15 (
      .clk(clk), .rst(rst), .start(start), .cfg_div(cfg_div), .cfg_ctrl(cfg_ctrl),
      .busy(busy15), .c_addr(c_addr15), .c_data(c_data15), .c_valid(c_valid15), .c_ready(c_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error), .rx_error_valid(rx_error_valid),
      .m_data(m_data15), .m_valid(m_valid15), .m_ready(m_ready), .err_count(err_count15),
      .last_error(last_error15), .overflow(overflow15), .resync(resync15));

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
      end
   endtask

   // Reference model: widx is the pending config write (-1 = none), mq the FIFO.
   logic [7:0] mq[$];
   int         widx = -1;
   bit         started = 0;
   logic [7:0] mcfg [3] = '{default: 8'h00};
   int         merr = 0, mlast = 0, mcons = 0;
   bit         movf = 0, mres = 0;

   always @(posedge clk or posedge rst) begin : model
      bit run, pop, acc;
      if (rst) begin
         mq.delete();
         widx = -1; started = 0; mcfg = '{default: 8'h00};
         merr = 0; mlast = 0; mcons = 0; movf = 0; mres = 0;
      end else begin
         run = started && widx < 0;
         pop = mq.size() > 0 && m_ready;
         acc = start && widx < 0;
         mres = 0;
         if (pop) void'(mq.pop_front());
         if (run && rx_valid) begin
            if (mq.size() < DEPTH) mq.push_back(rx_data);
            else if (!acc) movf = 1;
         end
         if (acc) begin
            mcfg = '{cfg_div[7:0], cfg_div[15:8], cfg_ctrl};
            widx = 0; started = 1; merr = 0; mlast = 0; mcons = 0; movf = 0;
         end else if (widx >= 0) begin
            if (c_ready) widx = (widx == 2) ? -1 : widx + 1;
         end else if (run) begin
            if (rx_error_valid) begin
               merr = (merr < 255) ? merr + 1 : 255;
               mlast = rx_error;
               mcons++;
               if (mcons == THRESH) begin mcons = 0; mres = 1; widx = 0; end
            end else if (rx_valid) mcons = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_on) begin
         chk("busy", busy, widx >= 0);
         chk("c_valid", c_valid, widx >= 0);
         if (widx >= 0) begin
            chk("c_addr", c_addr, widx);
            chk("c_data", c_data, mcfg[widx]);
         end
         chk("m_valid", m_valid, mq.size() > 0);
         if (mq.size() > 0) chk("m_data", m_data, mq[0]);
         chk("err_count", err_count, merr);
         chk("last_error", last_error, mlast);
         chk("overflow", overflow, movf);
         chk("resync", resync, mres);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (c_valid && c_ready) wlog.push_back({c_addr, c_data});
         if (m_valid && m_ready) plog.push_back(m_data);
         if (busy) nbusy++;
         if (resync) nres++;
         if (resync15) nres15++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b;
      cyc(1);
      rx_valid = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] d, input logic [7:0] c, input int stall, input bit glitch);
      cfg_div = d; cfg_ctrl = c; start = 1'b1;
      cyc(1);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         c_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            if (glitch && k == 1 && s == 0) begin
               start = 1'b1; cfg_div = 16'hBEEF; cfg_ctrl = 8'h5A;
            end
            cyc(1);
            start = 1'b0;
         end
         c_ready = 1'b1;
         cyc(1);
      end
   endtask

   initial begin
      rst = 1'b1;
      cyc(3);
      chk("rst busy", busy, 0);       chk("rst c_valid", c_valid, 0);
      chk("rst c_addr", c_addr, 0);   chk("rst c_data", c_data, 0);
      chk("rst m_valid", m_valid, 0); chk("rst m_data", m_data, 0);
      chk("rst err_count", err_count, 0); chk("rst last_error", last_error, 0);
      chk("rst overflow", overflow, 0);   chk("rst resync", resync, 0);
      rst = 1'b0;
      chk_on = 1;
      cyc(2);

      // Stalled config with an ignored start during WR_HI
      wlog.delete(); nbusy = 0;
      do_start(16'h1234, 8'hA5, 3, 1);
      chk("cfg writes", wlog.size(), 3);
      if (wlog.size() == 3) begin
         chk("cfg w0", wlog[0], 12'h034);
         chk("cfg w1", wlog[1], 12'h112);
         chk("cfg w2", wlog[2], 12'h2A5);
      end
      chk("cfg busy cycles", nbusy, 12);
      chk("cfg run reached", busy, 0);

      // FIFO order and throughput
      send(8'h11); send(8'h22); send(8'h33);
      plog.delete();
      m_ready = 1'b1;
      cyc(3);
      chk("pop count", plog.size(), 3);
      if (plog.size() == 3) begin
         chk("pop0", plog[0], 8'h11);
         chk("pop1", plog[1], 8'h22);
         chk("pop2", plog[2], 8'h33);
      end
      cyc(1);
      chk("fifo drained", m_valid, 0);
      m_ready = 1'b0;

      // Overflow, start clears it, FIFO survives, push-while-full-with-pop
      for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
      chk("overflow set", overflow, 1);
      do_start(16'h0302, 8'h07, 0, 0);
      chk("overflow cleared", overflow, 0);
      chk("fifo kept", m_valid, 1);
      plog.delete();
      m_ready = 1'b1;
      send(8'hA5);
      cyc(5);
      m_ready = 1'b0;
      chk("drain count", plog.size(), 5);
      if (plog.size() == 5) begin
         chk("drain0", plog[0], 8'hA0);
         chk("drain3", plog[3], 8'hA3);
         chk("drain4", plog[4], 8'hA5);
      end

      // Consecutive-error resync
      nres = 0; cfg_div = 16'hFFFF; cfg_ctrl = 8'hFF;
      rx_error = 2'd2; rx_error_valid = 1'b1;
      cyc(3);
      rx_error_valid = 1'b0;
      send(8'h55);
      chk("no early resync", nres, 0);
      chk("err after 3", err_count, 3);
      wlog.delete();
      rx_error = 2'd1; rx_error_valid = 1'b1;
      cyc(4);
      rx_error_valid = 1'b0;
      chk("err_count 7", err_count, 7);
      chk("last_error 1", last_error, 1);
      chk("resync pulse", resync, 1);
      cyc(4);
      chk("resync once", nres, 1);
      chk("resync writes", wlog.size(), 3);
      if (wlog.size() == 3) begin
         chk("rs w0", wlog[0], 12'h002);
         chk("rs w1", wlog[1], 12'h103);
         chk("rs w2", wlog[2], 12'h207);
      end

      // Saturation with ERR_THRESH=15 (second instance)
      m_ready = 1'b1;
      do_start(16'h00C8, 8'h3C, 0, 0);
      nres15 = 0;
      for (int i = 0; i < 300; i++) begin
         rx_error = 2'(i % 4); rx_error_valid = 1'b1;
         cyc(1);
         rx_error_valid = 1'b0;
         if (i % 10 == 9) send(8'(i));
      end
      cyc(1);
      chk("sat err_count", err_count15, 255);
      chk("sat last_error", last_error15, 3);
      chk("sat no resync", nres15, 0);
      cyc(5);
      m_ready = 1'b0;

      // Async reset during WR_CTRL
      send(8'h77);
      cfg_div = 16'hABCD; cfg_ctrl = 8'h6E; start = 1'b1;
      cyc(1);
      start = 1'b0; c_ready = 1'b1;
      cyc(2);
      c_ready = 1'b0;
      cyc(1);
      #2;
      chk("pre-rst c_valid", c_valid, 1);
      chk("pre-rst c_addr", c_addr, 2);
      chk("pre-rst c_data", c_data, 8'h6E);
      rst = 1'b1;
      #1;
      chk("arst busy", busy, 0);       chk("arst c_valid", c_valid, 0);
      chk("arst c_addr", c_addr, 0);   chk("arst c_data", c_data, 0);
      chk("arst m_valid", m_valid, 0); chk("arst m_data", m_data, 0);
      chk("arst err_count", err_count, 0); chk("arst last_error", last_error, 0);
      chk("arst overflow", overflow, 0);   chk("arst resync", resync, 0);
      @(posedge clk);
      #1;
      rst = 1'b0; c_ready = 1'b1;
      send(8'h99);
      cyc(1);
      chk("idle ignores rx", m_valid, 0);
      chk("idle not busy", busy, 0);
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
